// File: rtl/seg7_score_feeder_pkg.sv
// rtl/seg7_score_feeder_pkg.sv - shared types, sizes and BCD helper for the score feeder
// Purpose: FSM state type, display geometry, default divider taps and the
//          double-dabble nibble-adjust step used by the conversion engine.
// Ports:   none (package)
package seg7_score_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam int NUM_DIGITS    = 8;
  localparam int BCD_W         = 32;
  localparam int DEF_SCAN_DIV  = 17;
  localparam int DEF_BLINK_DIV = 25;

  // One double-dabble correction: every nibble >= 5 gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_score_feeder_if.sv
// rtl/seg7_score_feeder_if.sv - score input and display-side signal bundle
// Purpose: groups the score strobe, blink request and all display outputs.
// Signals: score_valid/score/blink_en (master -> feeder),
//          busy/update/data/point/les/clk_scan/clk_blink (feeder -> master).
interface seg7_score_feeder_if #(
  parameter int SCORE_W = 16
);
  import seg7_score_feeder_pkg::*;

  logic               score_valid;
  logic [SCORE_W-1:0] score;
  logic               blink_en;
  logic               busy;
  logic               update;
  logic [BCD_W-1:0]   data;
  logic [7:0]         point;
  logic [7:0]         les;
  logic [1:0]         clk_scan;
  logic               clk_blink;

  modport master (
    output score_valid, score, blink_en,
    input  busy, update, data, point, les, clk_scan, clk_blink
  );

  modport slave (
    input  score_valid, score, blink_en,
    output busy, update, data, point, les, clk_scan, clk_blink
  );

endinterface

// File: rtl/seg7_score_feeder_bin2bcd_seq.sv
// rtl/seg7_score_feeder_bin2bcd_seq.sv - sequential double-dabble binary to BCD engine
// Purpose: one adjust+shift step per cycle while step_i is high; start_i loads
//          a new binary value and clears the BCD accumulator and bit counter.
// Ports:   clk, rst (async, active-high), start_i, step_i, bin_i[SCORE_W],
//          done_o (this step is the last one), bcd_o[32].
module seg7_score_feeder_bin2bcd_seq
  import seg7_score_feeder_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [SCORE_W-1:0] bin_i,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

  logic [SCORE_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BCD_W+SCORE_W-1:0] shifted;

  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    shifted = {dabble_adjust(bcd_q), bin_q} << 1;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      bcd_d = shifted[BCD_W+SCORE_W-1:SCORE_W];
      bin_d = shifted[SCORE_W-1:0];
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o = step_i && (cnt_q == CNT_W'(SCORE_W - 1));
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_score_feeder.sv
// rtl/seg7_score_feeder.sv - binary score to packed BCD feeder with display timing
// Purpose: converts scores to 8-digit BCD, keeps a 1-deep newest-wins pending
//          slot for strobes arriving while busy, and derives scan/blink clocks
//          from one free-running divider.
// Ports:   clk, rst (async, active-high), bus (slave modport of seg7_score_feeder_if).
module seg7_score_feeder
  import seg7_score_feeder_pkg::*;
#(
  parameter int SCORE_W   = 16,
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input logic                clk,
  input logic                rst,
  seg7_score_feeder_if.slave bus
);

  state_e               state_q, state_d;
  logic [BLINK_DIV-1:0] div_q;
  logic                 pend_v_q, pend_v_d;
  logic [SCORE_W-1:0]   pend_val_q, pend_val_d;
  logic [7:0]           les_q;
  logic [BCD_W-1:0]     data_q, data_d;
  logic                 update_q, update_d;

  logic                 eng_start;
  logic [SCORE_W-1:0]   eng_bin;
  logic                 eng_done;
  logic [BCD_W-1:0]     eng_bcd;

  seg7_score_feeder_bin2bcd_seq #(.SCORE_W(SCORE_W)) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (eng_start),
    .step_i  (state_q == ST_CONV),
    .bin_i   (eng_bin),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd)
  );

  always_comb begin
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_val_d = pend_val_q;
    data_d     = data_q;
    update_d   = 1'b0;
    eng_start  = 1'b0;
    eng_bin    = bus.score_valid ? bus.score : pend_val_q;
    case (state_q)
      ST_IDLE: begin
        // A fresh strobe beats the pending value; either way the slot empties.
        if (bus.score_valid || pend_v_q) begin
          eng_start = 1'b1;
          pend_v_d  = 1'b0;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        if (eng_done) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        data_d   = eng_bcd;
        update_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && bus.score_valid) begin
      pend_v_d   = 1'b1;
      pend_val_d = bus.score;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_val_q <= '0;
      les_q      <= '0;
      data_q     <= '0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_q + 1'b1;
      pend_v_q   <= pend_v_d;
      pend_val_q <= pend_val_d;
      les_q      <= {8{bus.blink_en}};
      data_q     <= data_d;
      update_q   <= update_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.update    = update_q;
  assign bus.data      = data_q;
  assign bus.point     = 8'h00;
  assign bus.les       = les_q;
  assign bus.clk_scan  = div_q[SCAN_DIV-1 -: 2];
  assign bus.clk_blink = div_q[BLINK_DIV-1];

endmodule

// File: tb/tb_seg7_score_feeder.sv
// tb/tb_seg7_score_feeder.sv - self-checking bench for seg7_score_feeder
module tb_seg7_score_feeder;

  localparam int SW = 16;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  seg7_score_feeder_if #(.SCORE_W(SW)) bus ();

  seg7_score_feeder #(.SCORE_W(SW), .SCAN_DIV(3), .BLINK_DIV(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int unsigned v);
    bus.score_valid = 1'b1;
    bus.score       = SW'(v);
    tick();
    bus.score_valid = 1'b0;
  endtask

  task automatic wait_update(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      if (bus.update === 1'b1) got = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.score_valid = 1'b1;
    bus.score       = SW'(1234);
    bus.blink_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.update !== 1'b0) $display("FAIL reset_update got %b want 0", bus.update); else n_pass++;
    n_total++; if (bus.data !== 32'h0) $display("FAIL reset_data got %h want 0", bus.data); else n_pass++;
    n_total++; if (bus.les !== 8'h00) $display("FAIL reset_les got %h want 00", bus.les); else n_pass++;
    n_total++; if (bus.clk_scan !== 2'd0) $display("FAIL reset_scan got %0d want 0", bus.clk_scan); else n_pass++;
    n_total++; if (bus.clk_blink !== 1'b0) $display("FAIL reset_blink got %b want 0", bus.clk_blink); else n_pass++;
    n_total++; if (bus.point !== 8'h00) $display("FAIL reset_point got %h want 00", bus.point); else n_pass++;
    bus.score_valid = 1'b0;
    bus.blink_en    = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    strobe(1234);
    for (int c = 0; c <= 18; c++) begin
      n_total++;
      if (bus.busy !== (c <= 16)) $display("FAIL single_busy c=%0d got %b want %b", c, bus.busy, (c <= 16));
      else n_pass++;
      n_total++;
      if (bus.update !== (c == 17)) $display("FAIL single_update c=%0d got %b want %b", c, bus.update, (c == 17));
      else n_pass++;
      if (c == 17) begin
        n_total++;
        if (bus.data !== 32'h0000_1234) $display("FAIL single_data got %h want 00001234", bus.data);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_max_zero();
    bit got;
    strobe(65535);
    wait_update(40, got);
    n_total++; if (!got) $display("FAIL max_update timeout got 0 want 1"); else n_pass++;
    n_total++; if (bus.data !== 32'h0006_5535) $display("FAIL max_data got %h want 00065535", bus.data); else n_pass++;
    tick();
    strobe(0);
    wait_update(40, got);
    n_total++; if (!got) $display("FAIL zero_update timeout got 0 want 1"); else n_pass++;
    n_total++; if (bus.data !== 32'h0) $display("FAIL zero_data got %h want 00000000", bus.data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int          n_upd;
    logic [31:0] seen[$];
    n_upd = 0;
    strobe(10);
    if (bus.update === 1'b1) begin n_upd++; seen.push_back(bus.data); end
    repeat (3) begin
      tick();
      if (bus.update === 1'b1) begin n_upd++; seen.push_back(bus.data); end
    end
    strobe(42);
    tick();
    strobe(77);
    for (int i = 0; i < 60; i++) begin
      if (bus.update === 1'b1) begin n_upd++; seen.push_back(bus.data); end
      tick();
    end
    n_total++; if (n_upd != 2) $display("FAIL b2b_count got %0d want 2", n_upd); else n_pass++;
    n_total++;
    if (seen.size() < 1 || seen[0] !== 32'h10) $display("FAIL b2b_first got %h want 00000010", (seen.size() > 0) ? seen[0] : 32'hx);
    else n_pass++;
    n_total++;
    if (seen.size() < 2 || seen[1] !== 32'h77) $display("FAIL b2b_second got %h want 00000077", (seen.size() > 1) ? seen[1] : 32'hx);
    else n_pass++;
  endtask

  task automatic test_divider();
    do_reset();
    for (int j = 1; j <= 64; j++) begin
      tick();
      n_total++;
      if (bus.clk_scan !== 2'((j / 2) % 4)) $display("FAIL div_scan j=%0d got %0d want %0d", j, bus.clk_scan, (j / 2) % 4);
      else n_pass++;
      n_total++;
      if (bus.clk_blink !== 1'((j / 16) % 2)) $display("FAIL div_blink j=%0d got %b want %0d", j, bus.clk_blink, (j / 16) % 2);
      else n_pass++;
    end
    n_total++; if (bus.les !== 8'h00) $display("FAIL les_off got %h want 00", bus.les); else n_pass++;
    bus.blink_en = 1'b1;
    n_total++; if (bus.les !== 8'h00) $display("FAIL les_latency got %h want 00", bus.les); else n_pass++;
    tick();
    n_total++; if (bus.les !== 8'hFF) $display("FAIL les_on got %h want FF", bus.les); else n_pass++;
    bus.blink_en = 1'b0;
    tick();
    n_total++; if (bus.les !== 8'h00) $display("FAIL les_back got %h want 00", bus.les); else n_pass++;
  endtask

  task automatic test_random();
    int unsigned m_rem, m_cur, m_pval;
    bit          m_pv, m_upd, sv;
    logic [31:0] m_data;
    int unsigned sc;
    do_reset();
    m_rem = 0; m_cur = 0; m_pval = 0; m_pv = 0; m_upd = 0; m_data = '0;
    for (int i = 0; i < 400; i++) begin
      sv = (i < 360) && ($urandom_range(0, 7) == 0);
      sc = $urandom_range(0, 65535);
      bus.score_valid = sv;
      bus.score       = SW'(sc);
      tick();
      m_upd = 0;
      if (m_rem == 0) begin
        if (sv) begin m_cur = sc; m_pv = 0; m_rem = SW + 1; end
        else if (m_pv) begin m_cur = m_pval; m_pv = 0; m_rem = SW + 1; end
      end else begin
        if (sv) begin m_pv = 1; m_pval = sc; end
        m_rem--;
        if (m_rem == 0) begin m_data = to_bcd(m_cur); m_upd = 1; end
      end
      n_total++;
      if (bus.busy !== (m_rem != 0) || bus.update !== m_upd || bus.data !== m_data)
        $display("FAIL rand i=%0d busy/upd/data got %b/%b/%h want %b/%b/%h",
                 i, bus.busy, bus.update, bus.data, (m_rem != 0), m_upd, m_data);
      else n_pass++;
    end
    bus.score_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got;
    strobe(8888);
    wait_update(40, got);
    n_total++; if (bus.data !== 32'h0000_8888) $display("FAIL pre_data got %h want 00008888", bus.data); else n_pass++;
    tick();
    strobe(999);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL mid_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.data !== 32'h0) $display("FAIL mid_data got %h want 0", bus.data); else n_pass++;
    n_total++; if (bus.update !== 1'b0) $display("FAIL mid_update got %b want 0", bus.update); else n_pass++;
    tick();
    rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.update === 1'b1 || bus.busy === 1'b1) got = 1'b1;
    end
    n_total++; if (got) $display("FAIL mid_no_resume got activity want none"); else n_pass++;
    strobe(5);
    wait_update(40, got);
    n_total++; if (!got) $display("FAIL post_update timeout got 0 want 1"); else n_pass++;
    n_total++; if (bus.data !== 32'h0000_0005) $display("FAIL post_data got %h want 00000005", bus.data); else n_pass++;
  endtask

  initial begin
    rst             = 1'b1;
    bus.score_valid = 1'b0;
    bus.score       = '0;
    bus.blink_en    = 1'b0;
    test_reset();
    test_single();
    test_max_zero();
    test_back_to_back();
    test_divider();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
